mul_share_ctrl: RTL and testbench
=================================

// Module: mul_share_ctrl
// PURPOSE
//  Issue controller that shares the single 16x16 combinational array multiplier between two
//  requesters (0: CPU execute stage, 1: address/DSP helper). Arbitrates round-robin, registers the
//  operands onto the multiplier and holds them for a fixed settle time. It then captures the
//  32-bit product as lo/hi halves and returns it over a valid/ready response to the granted requester.
// PARAMETERS
//  WIDTH   16  operand width; product is 2*WIDTH, split into lo/hi halves of WIDTH
//  SETTLE  2   cycles operands are held on the multiplier before capture; legal range 1..15
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst        in   1      reset, asynchronous assert, active-low (0 = reset)
//  req_valid  in   2      per-requester operation request
//  req_ready  out  2      per-requester accept; at most one bit high, only in IDLE
//  req0_a     in   WIDTH  requester 0 operand a
//  req0_b     in   WIDTH  requester 0 operand b
//  req1_a     in   WIDTH  requester 1 operand a
//  req1_b     in   WIDTH  requester 1 operand b
//  rsp_valid  out  2      per-requester result valid; one-hot or zero
//  rsp_ready  in   2      per-requester result accept
//  rsp_lo     out  WIDTH  product[WIDTH-1:0], shared by both requesters
//  rsp_hi     out  WIDTH  product[2*WIDTH-1:WIDTH]
//  rsp_ovf    out  1      1 when rsp_hi != 0; result does not fit in WIDTH
//  mul_a      out  WIDTH  registered operand a to the multiplier
//  mul_b      out  WIDTH  registered operand b to the multiplier
//  mul_enable out  1      high while operands are settling (BUSY)
//  mul_lo     in   WIDTH  multiplier low product half
//  mul_hi     in   WIDTH  multiplier high product half
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst=0): state IDLE, last_grant=1 so requester 0 wins first; all outputs 0. mul_a and mul_b
//    also clear. An operation or held response in flight is discarded; no rsp_valid after reset.
//  FSM: IDLE -> BUSY on accept; BUSY -> RESP when settle count reaches 0; RESP -> IDLE on the
//    rsp_valid[g] & rsp_ready[g] edge.
//  IDLE arbitration, combinational: only one valid -> grant it; both valid -> grant !last_grant.
//    req_ready[g]=1 for the grant only. Accept edge: latch g, update last_grant, load mul_a/mul_b from
//    reqg operands, load cnt=SETTLE-1, go BUSY.
//  BUSY: mul_enable=1. Per cycle: cnt!=0 -> cnt--; cnt==0 -> capture mul_lo/mul_hi into rsp_lo/rsp_hi,
//    set rsp_ovf=|mul_hi and rsp_valid[g]=1, go RESP.
//  Latency: rsp_valid rises exactly SETTLE edges after the accept edge (SETTLE=2: accept at E0, valid
//    after E2).
//  RESP: rsp_valid[g], rsp_lo/hi/ovf held stable until accepted; rsp_ready[!g] ignored. req_ready=0.
//  After response accept: back to IDLE, rsp_valid=0; the next accept can occur on the following edge.
//    Minimum issue interval is SETTLE+2 cycles.
//  Stability: mul_a/mul_b change only on an accept edge. rsp_lo/hi/ovf change only on a capture edge;
//    they keep stale data while rsp_valid=0.
//  req_valid dropping while not granted: no effect; a request cannot be withdrawn after its accept edge.
//  Arithmetic is unsigned only. Product = mul_hi:mul_lo, taken as given from the multiplier; no
//    rounding or saturation.
// STRUCTURE
//  Shared package mul_pkg: WIDTH constant, state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2),
//    requester-id constants REQ_EXE=0 and REQ_AUX=1.
//  Sub-module rr_arb2: 2-way round-robin arbiter, i.e. inputs req[1:0] and last, output one-hot gnt[1:0].
//  The multiplier is instantiated outside this block, beside it in the execute unit; this block only
//    drives and samples it.
// TESTING
//  1. Reset, then req0 3x5 alone -> req_ready=01; rsp_valid=01 SETTLE edges later; lo=0x000F, hi=0,
//     ovf=0.
//  2. Both requesters valid in the same cycle -> req0 is granted first, then req1 once req0's response
//     is accepted.
//     Both requesters held valid -> grants alternate 0,1,0,1.
//  3. req1 0xFFFF x 0xFFFF -> lo=0x0001, hi=0xFFFE, ovf=1; req1 0x1234 x 0x0100 -> lo=0x3400, hi=0x0012.
//  4. Response back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid and data stay stable; no new
//     req_ready; completes on rsp_ready=1.
//  5. rst=0 asynchronously mid-BUSY and again in RESP -> outputs 0 immediately; no stale rsp_valid;
//     next request is served by req0 first.
//  6. Sweep SETTLE=1 and SETTLE=4 -> latency equals SETTLE; mul_a/mul_b are constant throughout BUSY;
//     mul_enable is high for exactly SETTLE cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue controller: operand width,
// FSM state encoding and requester identifiers.
package mul_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_EXE = 1'b0;
  localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Issue controller sharing one external array multiplier between the execute
// stage and the address/DSP helper; holds operands SETTLE cycles, then returns the product.
module mul_share_ctrl #(
  parameter int WIDTH  = mul_pkg::WIDTH,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_ovf,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_enable,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic [WIDTH-1:0] mul_hi,
  output logic             busy
);

  import mul_pkg::*;

  state_t             r_state;
  logic               r_last;
  logic               r_g;
  logic [3:0]         r_cnt;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [WIDTH-1:0]   r_rsp_lo;
  logic [WIDTH-1:0]   r_rsp_hi;
  logic               r_rsp_ovf;
  logic [1:0]         r_rsp_valid;
  logic [1:0]         w_gnt;
  logic               w_idle;

  rr_arb2 u_arb (
    .req  (req_valid),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign w_idle     = (r_state == IDLE);
  assign req_ready  = w_idle ? w_gnt : 2'b00;
  assign busy       = !w_idle;
  assign mul_enable = (r_state == BUSY);
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign rsp_lo     = r_rsp_lo;
  assign rsp_hi     = r_rsp_hi;
  assign rsp_ovf    = r_rsp_ovf;
  assign rsp_valid  = r_rsp_valid;

  // Reset discards any operation or pending response and favours requester 0 next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_last      <= REQ_AUX;
      r_g         <= REQ_EXE;
      r_cnt       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_lo    <= '0;
      r_rsp_hi    <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_valid <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_g     <= w_gnt[1];
            r_last  <= w_gnt[1];
            r_mul_a <= w_gnt[1] ? req1_a : req0_a;
            r_mul_b <= w_gnt[1] ? req1_b : req0_b;
            r_cnt   <= 4'(SETTLE - 1);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_lo    <= mul_lo;
            r_rsp_hi    <= mul_hi;
            r_rsp_ovf   <= |mul_hi;
            r_rsp_valid <= r_g ? 2'b10 : 2'b01;
            r_state     <= RESP;
          end
        end
        RESP: begin
          // Only the granted requester's ready completes the handshake.
          if (rsp_ready[r_g]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural multiplier beside each instance.
module tb_mul_share_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [15:0] rsp_lo, rsp_hi, mul_a, mul_b, mul_lo, mul_hi;
  logic        rsp_ovf, mul_enable, busy;
  logic [31:0] prod;

  // Shared stimulus for the SETTLE=1 and SETTLE=4 instances
  logic [1:0]  sw_req_valid = 2'b00;
  logic [1:0]  sw_rsp_ready = 2'b00;
  logic [15:0] sw_a = '0, sw_b = '0;
  logic [1:0]  s1_req_ready, s1_rsp_valid, s4_req_ready, s4_rsp_valid;
  logic [15:0] s1_lo, s1_hi, s1_mul_a, s1_mul_b, s1_mlo, s1_mhi;
  logic [15:0] s4_lo, s4_hi, s4_mul_a, s4_mul_b, s4_mlo, s4_mhi;
  logic        s1_ovf, s1_en, s1_busy, s4_ovf, s4_en, s4_busy;
  logic [31:0] s1_prod, s4_prod;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign prod    = 32'(mul_a) * 32'(mul_b);
  assign mul_lo  = prod[15:0];
  assign mul_hi  = prod[31:16];
  assign s1_prod = 32'(s1_mul_a) * 32'(s1_mul_b);
  assign s1_mlo  = s1_prod[15:0];
  assign s1_mhi  = s1_prod[31:16];
  assign s4_prod = 32'(s4_mul_a) * 32'(s4_mul_b);
  assign s4_mlo  = s4_prod[15:0];
  assign s4_mhi  = s4_prod[31:16];

  mul_share_ctrl #(.WIDTH(16), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_ovf(rsp_ovf), .mul_a(mul_a), .mul_b(mul_b), .mul_enable(mul_enable),
    .mul_lo(mul_lo), .mul_hi(mul_hi), .busy(busy)
  );

  mul_share_ctrl #(.WIDTH(16), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .req_valid(sw_req_valid), .req_ready(s1_req_ready),
    .req0_a(sw_a), .req0_b(sw_b), .req1_a(sw_a), .req1_b(sw_b),
    .rsp_valid(s1_rsp_valid), .rsp_ready(sw_rsp_ready), .rsp_lo(s1_lo), .rsp_hi(s1_hi),
    .rsp_ovf(s1_ovf), .mul_a(s1_mul_a), .mul_b(s1_mul_b), .mul_enable(s1_en),
    .mul_lo(s1_mlo), .mul_hi(s1_mhi), .busy(s1_busy)
  );

  mul_share_ctrl #(.WIDTH(16), .SETTLE(4)) u_s4 (
    .clk(clk), .rst(rst), .req_valid(sw_req_valid), .req_ready(s4_req_ready),
    .req0_a(sw_a), .req0_b(sw_b), .req1_a(sw_a), .req1_b(sw_b),
    .rsp_valid(s4_rsp_valid), .rsp_ready(sw_rsp_ready), .rsp_lo(s4_lo), .rsp_hi(s4_hi),
    .rsp_ovf(s4_ovf), .mul_a(s4_mul_a), .mul_b(s4_mul_b), .mul_enable(s4_en),
    .mul_lo(s4_mlo), .mul_hi(s4_mhi), .busy(s4_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctrl"}, 64'({req_ready, rsp_valid, rsp_ovf, mul_enable, busy}), 64'd0);
    chk({tag, "_mul"},  64'({mul_a, mul_b}), 64'd0);
    chk({tag, "_rsp"},  64'({rsp_lo, rsp_hi}), 64'd0);
  endtask

  // Starts one cycle after a rising edge; returns one cycle after the accept edge.
  task automatic accept(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic [1:0] exp_g);
    req_valid = v;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    chk("req_ready", 64'(req_ready), 64'(exp_g));
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic wait_rsp(input logic [1:0] exp_g, input logic [15:0] lo,
                          input logic [15:0] hi, input logic ovf);
    int lat;
    lat = 0;
    while (rsp_valid == 2'b00 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency",   64'(lat), 64'd2);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_g));
    chk("rsp_lo",    64'(rsp_lo), 64'(lo));
    chk("rsp_hi",    64'(rsp_hi), 64'(hi));
    chk("rsp_ovf",   64'(rsp_ovf), 64'(ovf));
  endtask

  task automatic ack();
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    chk("idle_after_ack", 64'({busy, rsp_valid}), 64'd0);
  endtask

  initial begin
    int lat1, lat4, en1, en4, bad;
    logic [15:0] lo1, hi1, lo4, hi4;

    // 1: reset state, then 3 x 5 from requester 0 alone
    #12;
    chk_reset_state("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    accept(2'b01, 16'd3, 16'd5, 16'd0, 16'd0, 2'b01);
    wait_rsp(2'b01, 16'h000F, 16'h0000, 1'b0);
    ack();

    // 2: both held valid after a fresh reset alternate 0,1,0,1
    rst = 1'b0; #2; rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0]  g;
      logic [15:0] lo;
      g  = (i % 2 == 0) ? 2'b01 : 2'b10;
      lo = (i % 2 == 0) ? 16'((16 + i) * 2) : 16'((32 + i) * 3);
      accept(2'b11, 16'(16 + i), 16'd2, 16'(32 + i), 16'd3, g);
      wait_rsp(g, lo, 16'h0000, 1'b0);
      ack();
    end

    // 3: requester 1 wide products
    accept(2'b10, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 2'b10);
    wait_rsp(2'b10, 16'h0001, 16'hFFFE, 1'b1);
    ack();
    accept(2'b10, 16'd0, 16'd0, 16'h1234, 16'h0100, 2'b10);
    wait_rsp(2'b10, 16'h3400, 16'h0012, 1'b1);
    ack();

    // 4: back-pressure; ready on the wrong requester is ignored
    accept(2'b01, 16'd7, 16'd9, 16'd0, 16'd0, 2'b01);
    wait_rsp(2'b01, 16'h003F, 16'h0000, 1'b0);
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(rsp_valid), 64'h1);
      chk("bp_data",  64'({rsp_lo, rsp_hi, 15'd0, rsp_ovf}), 64'({16'h003F, 16'h0000, 16'h0000}));
      chk("bp_ready", 64'(req_ready), 64'h0);
    end
    req_valid = 2'b00;
    ack();

    // 5: asynchronous reset mid-BUSY, then in RESP
    accept(2'b01, 16'd4, 16'd4, 16'd0, 16'd0, 2'b01);
    #3; rst = 1'b0; #1;
    chk_reset_state("rst_busy");
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy_stale", 64'({busy, rsp_valid}), 64'd0);
    accept(2'b01, 16'd5, 16'd6, 16'd0, 16'd0, 2'b01);
    wait_rsp(2'b01, 16'h001E, 16'h0000, 1'b0);
    #3; rst = 1'b0; #1;
    chk_reset_state("rst_resp");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_resp_stale", 64'({busy, rsp_valid}), 64'd0);
    accept(2'b11, 16'd2, 16'd3, 16'd4, 16'd5, 2'b01);
    wait_rsp(2'b01, 16'h0006, 16'h0000, 1'b0);
    ack();

    // 6: SETTLE=1 and SETTLE=4 side by side
    sw_a = 16'h0102; sw_b = 16'h0304; sw_req_valid = 2'b01;
    #1;
    chk("sw_ready", 64'({s1_req_ready, s4_req_ready}), 64'({2'b01, 2'b01}));
    @(posedge clk); #1;
    sw_req_valid = 2'b00;
    sw_rsp_ready = 2'b11;
    lat1 = 0; lat4 = 0; en1 = 0; en4 = 0; bad = 0;
    lo1 = '0; hi1 = '0; lo4 = '0; hi4 = '0;
    for (int c = 0; c < 8; c++) begin
      if (s1_en) begin
        en1++;
        if (s1_mul_a != 16'h0102 || s1_mul_b != 16'h0304) bad++;
      end
      if (s4_en) begin
        en4++;
        if (s4_mul_a != 16'h0102 || s4_mul_b != 16'h0304) bad++;
      end
      if (s1_rsp_valid != 2'b00 && lat1 == 0) begin lat1 = c; lo1 = s1_lo; hi1 = s1_hi; end
      if (s4_rsp_valid != 2'b00 && lat4 == 0) begin lat4 = c; lo4 = s4_lo; hi4 = s4_hi; end
      @(posedge clk); #1;
    end
    sw_rsp_ready = 2'b00;
    chk("s1_latency", 64'(lat1), 64'd1);
    chk("s4_latency", 64'(lat4), 64'd4);
    chk("s1_enable",  64'(en1), 64'd1);
    chk("s4_enable",  64'(en4), 64'd4);
    chk("sw_mul_hold", 64'(bad), 64'd0);
    chk("s1_product", 64'({hi1, lo1}), 64'h0003_0A08);
    chk("s4_product", 64'({hi4, lo4}), 64'h0003_0A08);
    chk("sw_idle", 64'({s1_busy, s4_busy}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
